// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: owns the PC and drives the instruction memory.
// Captures fetched words into the IF/ID register under flush, stall and branch control.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic        state_dbg
);

  typedef enum logic {
    ST_RST = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic [31:0] fetch_count_q;

  // Priority is flush > stall > branch > sequential. A taken branch keeps the
  // word fetched this cycle (delay slot); a flush discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RST;
      pc_q          <= RESET_PC;
      id_pc_q       <= 32'h0;
      id_inst_q     <= 32'h0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (flush) begin
            pc_q       <= {flush_pc[31:2], 2'b00};
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
            id_valid_q <= 1'b0;
          end else if (!stall) begin
            if (branch_taken) begin
              pc_q <= {branch_target[31:2], 2'b00};
            end else begin
              pc_q <= pc_q + 32'd4;
            end
            id_pc_q       <= pc_q;
            id_inst_q     <= inst_data;
            id_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign inst_ce     = (state_q == ST_RUN);
  assign inst_addr   = pc_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, stall, delay-slot
// branch, flush under stall, asynchronous mid-run reset and PC wrap.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_count;
  logic        state_dbg;

  int checks;
  int failures;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_ce      (inst_ce),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count),
    .state_dbg    (state_dbg)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational instruction memory: word 0 is fixed, others tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h3c1e_1001;
    return {16'hDEAD, addr[15:0]};
  endfunction

  assign inst_data = mem_word(inst_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] addr, input logic valid,
                        input logic [31:0] ipc, input logic [31:0] iinst,
                        input logic [31:0] cnt);
    chk({tag, "_addr"},  inst_addr, addr);
    chk({tag, "_valid"}, {31'h0, id_valid}, {31'h0, valid});
    chk({tag, "_idpc"},  id_pc, ipc);
    chk({tag, "_inst"},  id_inst, iinst);
    chk({tag, "_cnt"},   fetch_count, cnt);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    flush         = 1'b0;
    flush_pc      = 32'h0;

    // Reset held for three edges
    step(); step(); step();
    chk("rst_ce", {31'h0, inst_ce}, 32'h0);
    chk("rst_state", {31'h0, state_dbg}, 32'h0);
    chk_if("rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ce", {31'h0, inst_ce}, 32'h0);

    // First edge: RST->RUN, nothing captured
    step();
    chk("run_ce", {31'h0, inst_ce}, 32'h1);
    chk_if("e1", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Second edge: first valid word
    step();
    chk_if("e2", 32'h4, 1'b1, 32'h0, 32'h3c1e_1001, 32'h1);

    // Sequential fetch up to inst_addr = 0x10
    for (int k = 2; k <= 4; k++) begin
      step();
      chk_if("seq", 32'(4 * k), 1'b1, 32'(4 * (k - 1)), {16'hDEAD, 16'(4 * (k - 1))}, 32'(k));
    end

    // Stall three cycles at pc=0x10; branch_taken during stall is ignored
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_if("stall", 32'h10, 1'b1, 32'hC, 32'hDEAD_000C, 32'h4);
    end

    // Branch from id_pc=0x0C while fetching 0x10: delay slot kept, target 0x16 -> 0x14
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0016;
    step();
    chk_if("br", 32'h14, 1'b1, 32'h10, 32'hDEAD_0010, 32'h5);
    branch_taken = 1'b0;

    step();
    chk_if("seq5", 32'h18, 1'b1, 32'h14, 32'hDEAD_0014, 32'h6);
    step();
    chk_if("seq6", 32'h1C, 1'b1, 32'h18, 32'hDEAD_0018, 32'h7);
    step();
    chk_if("seq7", 32'h20, 1'b1, 32'h1C, 32'hDEAD_001C, 32'h8);

    // Flush wins over stall; low PC bits cleared; in-flight word discarded
    flush    = 1'b1;
    stall    = 1'b1;
    flush_pc = 32'h0000_0083;
    step();
    chk_if("flush", 32'h80, 1'b0, 32'h0, 32'h0, 32'h8);
    flush = 1'b0;
    stall = 1'b0;
    step();
    chk_if("postfl", 32'h84, 1'b1, 32'h80, 32'hDEAD_0080, 32'h9);

    // Move to pc=0x40, then assert reset between edges
    flush    = 1'b1;
    flush_pc = 32'h0000_0040;
    step();
    flush = 1'b0;
    chk_if("to40", 32'h40, 1'b0, 32'h0, 32'h0, 32'h9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ce", {31'h0, inst_ce}, 32'h0);
    chk_if("arst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rerun_ce", {31'h0, inst_ce}, 32'h1);

    // PC wrap from 0xFFFF_FFFC
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFE;
    step();
    flush = 1'b0;
    chk_if("wrap0", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk_if("wrap1", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_FFFC, 32'h1);
    step();
    chk_if("wrap2", 32'h4, 1'b1, 32'h0, 32'h3c1e_1001, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the chip-enable and byte address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. It handles pipeline stall, delayed-branch/jump redirect from ID, and flush redirect from the exception/control unit. The block sits between the control logic and the instruction memory on one side and the decode stage on the other.

## Interface
- RESET_PC, 32'h0000_0000, PC value held during reset; first fetch address after reset.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- branch_taken  input  1  ID-stage redirect request (branch or jump taken).
- branch_target  input  32  redirect address; bits [1:0] ignored (forced to 0).
- flush  input  1  squash request from exception/control unit.
- flush_pc  input  32  new PC on flush; bits [1:0] forced to 0.
- inst_ce  output  1  instruction memory chip enable.
- inst_addr  output  32  instruction memory byte address (= pc).
- inst_data  input  32  instruction word, valid combinationally in the same cycle as inst_addr.
- id_pc  output  32  PC of instruction held in IF/ID.
- id_inst  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

## Operation
- States: RST (ce=0) and RUN (ce=1). rst asserted forces RST asynchronously; first rising edge with rst low moves RST->RUN. No other transitions.
- RST: pc=RESET_PC, inst_ce=0, id_pc=0, id_inst=0, id_valid=0, fetch_count=0.
- RUN, per edge, priority flush > stall > branch_taken > sequential:
  - flush: pc <= {flush_pc[31:2],2'b00}; IF/ID <= bubble (id_inst=0, id_pc=0, id_valid=0); fetch_count unchanged. Applies even if stall is high.
  - stall (no flush): pc, IF/ID, fetch_count all hold. branch_taken ignored (ID re-presents it once stall drops).
  - branch_taken: pc <= {branch_target[31:2],2'b00}; IF/ID <= {pc, inst_data, valid=1} — the word currently fetched is the delay slot and is kept; fetch_count += 1.
  - otherwise: pc <= pc + 4; IF/ID <= {pc, inst_data, 1}; fetch_count += 1.
- In the RST->RUN edge itself nothing is captured; IF/ID stays a bubble, pc stays RESET_PC.
- inst_addr = pc combinationally; inst_ce = (state==RUN). id_inst must capture inst_data only when inst_ce=1.
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count wraps modulo 2^32. No error flag.

## Timing
- Fetch latency: address presented cycle N, word visible on id_inst after edge ending cycle N (1 cycle).
- Redirect latency: branch_taken/flush sampled at edge E; inst_addr shows target in the cycle following E.
- One delay slot for branch_taken; zero slots for flush (the in-flight word is discarded).
- Reset deassertion to first valid id_valid: 2 rising edges.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), independent of clk.

## Test plan
- Reset/startup: RESET_PC=0, hold rst 3 cycles, release -> inst_ce=0 until first edge; inst_addr 0,0,4,8; id_valid rises on 2nd edge with id_pc=0, id_inst=mem[0]=32'h3c1e1001.
- Sequential fetch 8 words -> id_pc 0,4,…,0x1C each one cycle after inst_addr; fetch_count=8.
- Stall 3 cycles at pc=0x10 -> inst_addr stays 0x10, id_pc/id_inst/fetch_count frozen; resumes with 0x14 after release.
- Branch at id_pc=0x0C (branch_taken=1, target=0x16) while fetching 0x10 -> next inst_addr=0x14 (low bits cleared), id_pc=0x10 (delay slot, id_valid=1).
- flush with stall=1, flush_pc=0x80 -> id_valid=0, id_inst=0, inst_addr=0x80 next cycle, fetch_count unchanged; stall+branch_taken together -> pc unchanged.
- Assert rst asynchronously between edges at pc=0x40 -> inst_ce, id_valid, fetch_count 0 and inst_addr=RESET_PC immediately; wrap test from pc=0xFFFF_FFFC -> 0x0.
